// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the instruction
// fetch port (i_*) and the load/store port (d_*). Ties between the two go
// round-robin. Each access runs IDLE -> BUSY -> DONE. A watchdog aborts a
// BUSY phase that waits too long for mem_ready.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_done,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_err,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_done,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_err,
  output logic                mem_valid,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_nx;

  // Control: last_d/own_d are 1 when the data port holds the grant.
  logic        last_d;
  logic        own_d;
  logic [31:0] cnt;
  logic        grant;
  logic        grant_d;
  logic        finish;
  logic        timed_out;

  // Request stage: fields captured at grant, replayed on the memory bus.
  logic [ADDR_W-1:0] addr_p1;
  logic              we_p1;
  logic [DATA_W-1:0] wdata_p1;
  logic [STRB_W-1:0] wstrb_p1;

  // Result stage: data and error returned to the owner in DONE.
  logic [DATA_W-1:0] rdata_p2;
  logic              err_p2;

  // Next-state decode, arbitration and output drive.
  always_comb begin
    state_nx  = state;
    grant     = 1'b0;
    grant_d   = 1'b0;
    finish    = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) begin
          grant    = 1'b1;
          grant_d  = (i_req && d_req) ? !last_d : d_req;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          finish   = 1'b1;
          state_nx = DONE;
        end else if (TIMEOUT != 0 && (cnt + 32'd1) == 32'(TIMEOUT)) begin
          timed_out = 1'b1;
          state_nx  = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    mem_valid = (state == BUSY);
    mem_we    = mem_valid & we_p1;
    mem_addr  = mem_valid ? addr_p1  : '0;
    mem_wdata = mem_valid ? wdata_p1 : '0;
    mem_wstrb = mem_valid ? wstrb_p1 : '0;

    i_done  = (state == DONE) && !own_d;
    d_done  = (state == DONE) && own_d;
    i_rdata = i_done ? rdata_p2 : '0;
    d_rdata = d_done ? rdata_p2 : '0;
    i_err   = i_done & err_p2;
    d_err   = d_done & err_p2;
  end

  // State register, grant history and watchdog counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      last_d <= 1'b0;
      own_d  <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        own_d  <= grant_d;
        last_d <= grant_d;
        cnt    <= '0;
      end else if (state == BUSY) begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  // Request and result capture; visibility is gated by state, so no reset.
  always_ff @(posedge clk) begin
    if (grant) begin
      addr_p1  <= grant_d ? d_addr : i_addr;
      we_p1    <= grant_d & d_we;
      wdata_p1 <= grant_d ? d_wdata : '0;
      wstrb_p1 <= (grant_d && d_we) ? d_wstrb : '0;
    end
    if (finish || timed_out) begin
      rdata_p2 <= (finish && !we_p1) ? mem_rdata : '0;
      err_p2   <= timed_out;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed steps plus randomized accesses,
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          i_req, d_req, d_we, mem_ready;
  logic [AW-1:0] i_addr, d_addr, mem_addr;
  logic [DW-1:0] d_wdata, mem_rdata, i_rdata, d_rdata, mem_wdata;
  logic [3:0]    d_wstrb, mem_wstrb;
  logic          i_done, i_err, d_done, d_err, mem_valid, mem_we;

  int compared = 0;
  int failed   = 0;
  bit last_w;  // model: 1 when the data port won the previous grant

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rand_fields();
    i_addr  = $urandom & 32'hFFFF_FFFC;
    d_addr  = $urandom & 32'hFFFF_FFFC;
    d_we    = 1'($urandom);
    d_wdata = $urandom;
    d_wstrb = 4'($urandom_range(1, 15));
  endtask

  // One access: set requests now (at a negedge), wait for the bus phase,
  // drive the memory side, then check the done cycle.
  task automatic serve(input bit ri, input bit rqd, input int waits, input bit tmo,
                       input int exp_lat, input bit drop, input logic [31:0] rd);
    bit            win_d, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd, erd;
    logic [3:0]    es;
    int            lat, nb;
    i_req = ri;
    d_req = rqd;
    win_d = (ri && rqd) ? !last_w : rqd;
    last_w = win_d;
    ewe = win_d && d_we;
    ea  = win_d ? d_addr : i_addr;
    ewd = d_wdata;
    es  = ewe ? d_wstrb : 4'h0;
    lat = 0;
    do begin
      mem_ready = 1'($urandom);
      mem_rdata = $urandom;
      @(negedge clk);
      lat++;
      if (!mem_valid) chk("idle_no_done", 32'({i_done, d_done}), 32'd0);
    end while (!mem_valid && lat < 6);
    chk("latency", 32'(lat), 32'(exp_lat));
    if (drop) begin
      if (win_d) d_req = 1'b0; else i_req = 1'b0;
      rand_fields();
    end
    nb = tmo ? TMO : waits + 1;
    for (int k = 0; k < nb; k++) begin
      chk("busy_valid", 32'(mem_valid), 32'd1);
      chk("busy_addr", mem_addr, ea);
      chk("busy_we", 32'(mem_we), 32'(ewe));
      chk("busy_strb", 32'(mem_wstrb), 32'(es));
      if (ewe) chk("busy_wdata", mem_wdata, ewd);
      chk("busy_no_done", 32'({i_done, d_done}), 32'd0);
      mem_ready = !tmo && (k == waits);
      mem_rdata = mem_ready ? rd : $urandom;
      @(negedge clk);
    end
    erd = (tmo || ewe) ? 32'd0 : rd;
    mem_ready = 1'($urandom);
    mem_rdata = $urandom;
    chk("done_valid_low", 32'(mem_valid), 32'd0);
    chk("i_done", 32'(i_done), 32'(!win_d));
    chk("d_done", 32'(d_done), 32'(win_d));
    chk("i_rdata", i_rdata, win_d ? 32'd0 : erd);
    chk("d_rdata", d_rdata, win_d ? erd : 32'd0);
    chk("i_err", 32'(i_err), 32'(!win_d && tmo));
    chk("d_err", 32'(d_err), 32'(win_d && tmo));
  endtask

  initial begin
    int n;
    bit ri, rqd;
    reset_n = 1'b0;
    i_req = 0; d_req = 0; d_we = 0; i_addr = 0; d_addr = 0;
    d_wdata = 0; d_wstrb = 0; mem_ready = 0; mem_rdata = 0;
    last_w = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_done", 32'({i_done, d_done, i_err, d_err}), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);

    // Single fetch straight out of reset.
    reset_n = 1'b1;
    rand_fields();
    i_addr = 32'h100;
    serve(1, 0, 0, 0, 1, 0, 32'h0070_0393);

    // Store with three wait cycles.
    rand_fields();
    d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    serve(0, 1, 3, 0, 2, 0, $urandom);

    // Stray mem_ready while idle, then owner drops req mid-access.
    i_req = 0; d_req = 0;
    repeat (3) begin
      mem_ready = 1'b1;
      @(negedge clk);
      chk("stray_valid", 32'(mem_valid), 32'd0);
      chk("stray_done", 32'({i_done, d_done}), 32'd0);
    end
    rand_fields();
    serve(0, 1, 2, 0, 1, 1, $urandom);

    // Watchdog abort on a load, then a normal access.
    rand_fields();
    d_we = 1'b0;
    serve(0, 1, 0, 1, 2, 0, $urandom);
    rand_fields();
    serve(1, 1, 1, 0, 2, 0, $urandom);

    // Reset during a wait: bus drops, no done, tie goes to D afterwards.
    rand_fields();
    i_req = 1; d_req = 0; mem_ready = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_valid && n < 6);
    chk("mid_busy_reached", 32'(mem_valid), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 32'(mem_valid), 32'd0);
    chk("mid_rst_done", 32'({i_done, d_done}), 32'd0);
    reset_n = 1'b1;
    last_w = 1'b0;
    rand_fields();
    serve(1, 1, 0, 0, 1, 0, $urandom);
    repeat (3) begin
      rand_fields();
      serve(1, 1, 0, 0, 2, 0, $urandom);
    end

    // Randomized accesses.
    repeat (25) begin
      rand_fields();
      ri  = 1'($urandom);
      rqd = ri ? 1'($urandom) : 1'b1;
      serve(ri, rqd, $urandom_range(0, 4), 0, 2, ($urandom_range(0, 3) == 0), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
